t4_2_stage: RTL and testbench

Second half of the T4 stage of the fused multiply-add pipeline. Consumes the reduced Sum/Carry pair, leading-zero indicator and forwarded control produced by the T4 CSA/LZA stage. Performs the final carry-propagate addition with high-part increment, sign detection and conditional two's-complement, and encodes the leading-zero count. It runs as a 2-cycle internal pipeline with a valid token and feeds the normalization stage.

---
 rtl/t4_2_stage_pkg.sv | 23 ++
 rtl/t4_2_stage_if.sv | 45 ++++
 rtl/t4_2_stage_lzc_28.sv | 21 ++
 rtl/t4_2_stage.sv | 148 ++++++++++++++
 tb/tb_t4_2_stage.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/t4_2_stage_pkg.sv
// rtl/t4_2_stage_pkg.sv - shared constants and control bundle for the T4 second-half stage
package t4_2_stage_pkg;

  localparam logic [2:0] CONT_FULL   = 3'b000;
  localparam logic [2:0] CONT_DUAL   = 3'b001;
  localparam logic [2:0] CONT_NARROW = 3'b010;

  localparam int W_R   = 74;
  localparam int W_ADD = 48;
  localparam int W_HI  = 26;
  localparam int W_F   = 56;

  typedef struct packed {
    logic [2:0]  cont;
    logic [11:0] e;
    logic [11:0] d;
    logic [3:0]  trap_0;
    logic [3:0]  trap_1;
    logic [2:0]  trap_ans_0;
    logic [2:0]  trap_ans_1;
  } ctrl_t;

endpackage

// File: rtl/t4_2_stage_if.sv
// rtl/t4_2_stage_if.sv - input bundle and result bundle of the T4 second-half stage
interface t4_2_stage_if;
  import t4_2_stage_pkg::*;

  logic              in_valid;
  logic              flush;
  logic [2:0]        cont_T4_1;
  logic [W_R-1:0]    sh_reg_T4_1;
  logic [W_ADD-1:0]  Sum_in;
  logic [W_ADD:0]    Carry_in;
  logic [W_F-1:0]    F;
  logic              S_A_T4_1, S_B_T4_1, S_C_T4_1;
  logic              S_A_H_T4_1, S_B_H_T4_1, S_C_H_T4_1;
  logic [11:0]       E_T4_1, d_T4_1;
  logic [3:0]        trap_T4_1_0, trap_T4_1_1;
  logic [2:0]        trap_ans_T4_1_0, trap_ans_T4_1_1;

  logic              out_valid;
  logic [W_R-1:0]    R_T4_2;
  logic              S_R_T4_2, S_R_H_T4_2;
  logic [5:0]        lzc_0_T4_2, lzc_1_T4_2;
  logic [2:0]        cont_T4_2;
  logic [11:0]       E_T4_2, d_T4_2;
  logic [3:0]        trap_T4_2_0, trap_T4_2_1;
  logic [2:0]        trap_ans_T4_2_0, trap_ans_T4_2_1;

  modport slave (
    input  in_valid, flush, cont_T4_1, sh_reg_T4_1, Sum_in, Carry_in, F,
           S_A_T4_1, S_B_T4_1, S_C_T4_1, S_A_H_T4_1, S_B_H_T4_1, S_C_H_T4_1,
           E_T4_1, d_T4_1, trap_T4_1_0, trap_T4_1_1, trap_ans_T4_1_0, trap_ans_T4_1_1,
    output out_valid, R_T4_2, S_R_T4_2, S_R_H_T4_2, lzc_0_T4_2, lzc_1_T4_2,
           cont_T4_2, E_T4_2, d_T4_2, trap_T4_2_0, trap_T4_2_1,
           trap_ans_T4_2_0, trap_ans_T4_2_1
  );

  modport master (
    output in_valid, flush, cont_T4_1, sh_reg_T4_1, Sum_in, Carry_in, F,
           S_A_T4_1, S_B_T4_1, S_C_T4_1, S_A_H_T4_1, S_B_H_T4_1, S_C_H_T4_1,
           E_T4_1, d_T4_1, trap_T4_1_0, trap_T4_1_1, trap_ans_T4_1_0, trap_ans_T4_1_1,
    input  out_valid, R_T4_2, S_R_T4_2, S_R_H_T4_2, lzc_0_T4_2, lzc_1_T4_2,
           cont_T4_2, E_T4_2, d_T4_2, trap_T4_2_0, trap_T4_2_1,
           trap_ans_T4_2_0, trap_ans_T4_2_1
  );

endinterface

// File: rtl/t4_2_stage_lzc_28.sv
// rtl/t4_2_stage_lzc_28.sv - 28-bit leading-zero counter; an all-zero input counts 28
module t4_2_stage_lzc_28 (
  input  logic [27:0] i_data,
  output logic [4:0]  o_count,
  output logic        o_zero
);

  logic [4:0] w_count;

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    w_count = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (i_data[i]) w_count = 5'(27 - i);
    end
  end

  assign o_count = w_count;
  assign o_zero  = ~|i_data;

endmodule

// File: rtl/t4_2_stage.sv
// rtl/t4_2_stage.sv - T4 second half: final carry-propagate add, sign fix-up and LZ count, 2-cycle pipe
module t4_2_stage
  import t4_2_stage_pkg::*;
(
  input  logic         clk,
  input  logic         rstn,
  t4_2_stage_if.slave  bus
);

  logic [4:0]  w_lz_hi, w_lz_lo;
  logic        w_z_hi, w_z_lo;
  logic [24:0] w_l_sum;
  logic        w_ld_a, w_ld_b;
  ctrl_t       w_ctrl_in;
  logic        w_unused;

  logic        r_v1, r_v2;
  ctrl_t       r_ctrl_a, r_ctrl_b;
  logic [23:0] r_l, r_sum_hi, r_carry_hi;
  logic        r_c24, r_c48;
  logic [W_HI-1:0] r_sh_hi;
  logic        r_sub, r_sub_h, r_ps, r_ps_h;
  logic [4:0]  r_lz_hi, r_lz_lo;
  logic        r_z_hi, r_z_lo;

  logic [W_R-1:0] r_r;
  logic        r_s_r, r_s_r_h;
  logic [5:0]  r_lzc0, r_lzc1;

  t4_2_stage_lzc_28 u_lzc_hi (.i_data(bus.F[55:28]), .o_count(w_lz_hi), .o_zero(w_z_hi));
  t4_2_stage_lzc_28 u_lzc_lo (.i_data(bus.F[27:0]),  .o_count(w_lz_lo), .o_zero(w_z_lo));

  assign w_l_sum   = {1'b0, bus.Sum_in[23:0]} + {1'b0, bus.Carry_in[23:0]};
  assign w_ld_a    = bus.in_valid & ~bus.flush;
  assign w_ld_b    = r_v1 & ~bus.flush;
  assign w_ctrl_in = {bus.cont_T4_1, bus.E_T4_1, bus.d_T4_1, bus.trap_T4_1_0, bus.trap_T4_1_1,
                      bus.trap_ans_T4_1_0, bus.trap_ans_T4_1_1};
  assign w_unused  = ^bus.sh_reg_T4_1[47:0];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v1 <= 1'b0;       r_ctrl_a <= '0;     r_l <= '0;        r_c24 <= 1'b0;
      r_sum_hi <= '0;     r_carry_hi <= '0;   r_c48 <= 1'b0;    r_sh_hi <= '0;
      r_sub <= 1'b0;      r_sub_h <= 1'b0;    r_ps <= 1'b0;     r_ps_h <= 1'b0;
      r_lz_hi <= '0;      r_lz_lo <= '0;      r_z_hi <= 1'b0;   r_z_lo <= 1'b0;
    end else begin
      r_v1 <= w_ld_a;
      if (w_ld_a) begin
        r_ctrl_a   <= w_ctrl_in;
        r_l        <= w_l_sum[23:0];
        r_c24      <= w_l_sum[24];
        r_sum_hi   <= bus.Sum_in[47:24];
        r_carry_hi <= bus.Carry_in[47:24];
        r_c48      <= bus.Carry_in[48];
        r_sh_hi    <= bus.sh_reg_T4_1[73:48];
        r_sub      <= bus.S_A_T4_1 ^ bus.S_B_T4_1 ^ bus.S_C_T4_1;
        r_sub_h    <= bus.S_A_H_T4_1 ^ bus.S_B_H_T4_1 ^ bus.S_C_H_T4_1;
        r_ps       <= bus.S_A_T4_1 ^ bus.S_B_T4_1;
        r_ps_h     <= bus.S_A_H_T4_1 ^ bus.S_B_H_T4_1;
        r_lz_hi    <= w_lz_hi;
        r_lz_lo    <= w_lz_lo;
        r_z_hi     <= w_z_hi;
        r_z_lo     <= w_z_lo;
      end
    end
  end

  logic            w_cin, w_cu, w_neg0, w_neg1;
  logic [24:0]     w_u_sum;
  logic [W_HI-1:0] w_h_base, w_h;
  logic [W_R-1:0]  w_raw, w_r;
  logic [49:0]     w_lane1, w_lane1_r;
  logic [5:0]      w_lz56, w_lzc0, w_lzc1;
  logic            w_s_r, w_s_r_h;

  // Dual-lane keeps the lanes independent, so the low-lane carry never enters bit 24.
  assign w_cin    = (r_ctrl_a.cont == CONT_DUAL) ? 1'b0 : r_c24;
  assign w_u_sum  = {1'b0, r_sum_hi} + {1'b0, r_carry_hi} + {24'd0, w_cin};
  assign w_cu     = w_u_sum[24];
  assign w_h_base = (r_ctrl_a.cont == CONT_NARROW) ? '0 : r_sh_hi;
  assign w_h      = w_h_base + {25'd0, r_c48} + {25'd0, w_cu};
  assign w_raw    = {w_h, w_u_sum[23:0], r_l};
  assign w_lane1  = {w_h, w_u_sum[23:0]};
  assign w_lz56   = r_z_hi ? (r_z_lo ? 6'd56 : 6'd28 + {1'b0, r_lz_lo}) : {1'b0, r_lz_hi};

  always_comb begin
    w_r = '0; w_s_r = 1'b0; w_s_r_h = 1'b0; w_lzc0 = '0; w_lzc1 = '0;
    w_neg0 = 1'b0; w_neg1 = 1'b0; w_lane1_r = '0;
    case (r_ctrl_a.cont)
      CONT_FULL: begin
        w_neg0 = r_sub & w_raw[73];
        w_r    = w_neg0 ? (~w_raw + 74'd1) : w_raw;
        w_s_r  = r_ps ^ w_neg0;
        w_lzc0 = w_lz56;
      end
      CONT_NARROW: begin
        // The high part holds only the end-around carry; no carry means a negative difference.
        w_neg0 = r_sub & ~w_cu;
        w_r    = {w_raw[73:48], w_neg0 ? (~w_raw[47:0] + 48'd1) : w_raw[47:0]};
        w_s_r  = r_ps ^ w_neg0;
        w_lzc0 = w_lz56;
      end
      CONT_DUAL: begin
        w_neg1    = r_sub_h & w_lane1[49];
        w_neg0    = r_sub & r_l[23];
        w_lane1_r = w_neg1 ? (~w_lane1 + 50'd1) : w_lane1;
        w_r       = {w_lane1_r, w_neg0 ? (~r_l + 24'd1) : r_l};
        w_s_r     = r_ps ^ w_neg0;
        w_s_r_h   = r_ps_h ^ w_neg1;
        w_lzc0    = {1'b0, r_lz_lo};
        w_lzc1    = {1'b0, r_lz_hi};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v2 <= 1'b0; r_ctrl_b <= '0; r_r <= '0; r_s_r <= 1'b0; r_s_r_h <= 1'b0;
      r_lzc0 <= '0; r_lzc1 <= '0;
    end else begin
      r_v2 <= w_ld_b;
      if (w_ld_b) begin
        r_ctrl_b <= r_ctrl_a;
        r_r      <= w_r;
        r_s_r    <= w_s_r;
        r_s_r_h  <= w_s_r_h;
        r_lzc0   <= w_lzc0;
        r_lzc1   <= w_lzc1;
      end
    end
  end

  assign bus.out_valid       = r_v2;
  assign bus.R_T4_2          = r_r;
  assign bus.S_R_T4_2        = r_s_r;
  assign bus.S_R_H_T4_2      = r_s_r_h;
  assign bus.lzc_0_T4_2      = r_lzc0;
  assign bus.lzc_1_T4_2      = r_lzc1;
  assign bus.cont_T4_2       = r_ctrl_b.cont;
  assign bus.E_T4_2          = r_ctrl_b.e;
  assign bus.d_T4_2          = r_ctrl_b.d;
  assign bus.trap_T4_2_0     = r_ctrl_b.trap_0;
  assign bus.trap_T4_2_1     = r_ctrl_b.trap_1;
  assign bus.trap_ans_T4_2_0 = r_ctrl_b.trap_ans_0;
  assign bus.trap_ans_T4_2_1 = r_ctrl_b.trap_ans_1;

endmodule

// File: tb/tb_t4_2_stage.sv
// tb/tb_t4_2_stage.sv - scoreboard bench for t4_2_stage with directed vectors
module tb_t4_2_stage;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   errors = 0;
  int   tag = 1;
  logic [73:0] last_r = '0;

  typedef struct {
    int          cyc;
    logic [73:0] r;
    logic        s_r, s_r_h;
    logic [5:0]  lzc0, lzc1;
    logic [2:0]  cont;
    logic [11:0] e, d;
    logic [3:0]  t0, t1;
    logic [2:0]  a0, a1;
  } exp_t;

  exp_t q[$];

  t4_2_stage_if bus ();

  t4_2_stage dut (.clk(clk), .rstn(rstn), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [73:0] act, input logic [73:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Drives one bundle for one cycle; returns #1 after the capturing edge with in_valid still set.
  task automatic send(input logic [2:0] cont, input logic [73:0] sh, input logic [47:0] sum,
                      input logic [48:0] carry, input logic [55:0] f, input logic [5:0] sg,
                      input logic fl, input logic push, input logic [73:0] er,
                      input logic esr, input logic esrh, input logic [5:0] el0, input logic [5:0] el1);
    exp_t e;
    logic [11:0] t;
    t = 12'(tag * 37 + 5);
    tag++;
    bus.in_valid = 1'b1;     bus.flush = fl;          bus.cont_T4_1 = cont;
    bus.sh_reg_T4_1 = sh;    bus.Sum_in = sum;        bus.Carry_in = carry;  bus.F = f;
    {bus.S_A_T4_1, bus.S_B_T4_1, bus.S_C_T4_1, bus.S_A_H_T4_1, bus.S_B_H_T4_1, bus.S_C_H_T4_1} = sg;
    bus.E_T4_1 = t;          bus.d_T4_1 = ~t;
    bus.trap_T4_1_0 = t[3:0]; bus.trap_T4_1_1 = t[7:4];
    bus.trap_ans_T4_1_0 = t[2:0]; bus.trap_ans_T4_1_1 = t[10:8];
    if (push) begin
      e.cyc = cyc + 2; e.r = er; e.s_r = esr; e.s_r_h = esrh; e.lzc0 = el0; e.lzc1 = el1;
      e.cont = cont; e.e = t; e.d = ~t; e.t0 = t[3:0]; e.t1 = t[7:4]; e.a0 = t[2:0]; e.a1 = t[10:8];
      q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tagname);
    chk({tagname, "_valid"}, 74'(bus.out_valid), 74'd0);
    chk({tagname, "_R"},     bus.R_T4_2, 74'd0);
    chk({tagname, "_signs"}, 74'({bus.S_R_T4_2, bus.S_R_H_T4_2}), 74'd0);
    chk({tagname, "_lzc"},   74'({bus.lzc_0_T4_2, bus.lzc_1_T4_2}), 74'd0);
    chk({tagname, "_ctrl"},  74'({bus.cont_T4_2, bus.E_T4_2, bus.d_T4_2, bus.trap_T4_2_0,
                                  bus.trap_T4_2_1, bus.trap_ans_T4_2_0, bus.trap_ans_T4_2_1}), 74'd0);
  endtask

  // Monitor: every valid output must match the oldest expectation, at its expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      last_r = '0;
    end else if (bus.out_valid) begin
      if (q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL unexpected_out: got R=%0h with no token outstanding (cycle %0d)", bus.R_T4_2, cyc);
      end else begin
        e = q.pop_front();
        chk("latency", 74'(cyc), 74'(e.cyc));
        chk("R", bus.R_T4_2, e.r);
        chk("S_R", 74'(bus.S_R_T4_2), 74'(e.s_r));
        chk("S_R_H", 74'(bus.S_R_H_T4_2), 74'(e.s_r_h));
        chk("lzc_0", 74'(bus.lzc_0_T4_2), 74'(e.lzc0));
        chk("lzc_1", 74'(bus.lzc_1_T4_2), 74'(e.lzc1));
        chk("ctrl", 74'({bus.cont_T4_2, bus.E_T4_2, bus.d_T4_2, bus.trap_T4_2_0, bus.trap_T4_2_1,
                          bus.trap_ans_T4_2_0, bus.trap_ans_T4_2_1}),
                    74'({e.cont, e.e, e.d, e.t0, e.t1, e.a0, e.a1}));
      end
      last_r = bus.R_T4_2;
    end else begin
      chk("hold_R", bus.R_T4_2, last_r);
    end
  end

  initial begin
    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.cont_T4_1 = '0; bus.sh_reg_T4_1 = '0;
    bus.Sum_in = '0; bus.Carry_in = '0; bus.F = '0;
    {bus.S_A_T4_1, bus.S_B_T4_1, bus.S_C_T4_1, bus.S_A_H_T4_1, bus.S_B_H_T4_1, bus.S_C_H_T4_1} = '0;
    bus.E_T4_1 = '0; bus.d_T4_1 = '0; bus.trap_T4_1_0 = '0; bus.trap_T4_1_1 = '0;
    bus.trap_ans_T4_1_0 = '0; bus.trap_ans_T4_1_1 = '0;
    #1 rstn = 1'b0;
    #2 chk_zero("reset");
    @(posedge clk); #1 rstn = 1'b1;
    idle(1);

    // full add with carry out of bit 23; F=0 counts 56
    send(3'b000, 74'd0, 48'h000000FFFFFF, 49'd1, 56'd0, 6'b000000, 0, 1,
         74'h1000000, 0, 0, 6'd56, 6'd0);
    // full subtract giving -5; F[55]=1 counts 0
    send(3'b000, {26'h3FFFFFF, 48'd0}, 48'hFFFFFFFFFFFB, 49'd0, 56'h80000000000000, 6'b001000, 0, 1,
         74'd5, 1, 0, 6'd0, 6'd0);
    // dual lane: lane0 wraps to 0, no carry into bit 24
    send(3'b001, 74'd0, 48'h000000800000, 49'h000000800000, 56'h01000000000001, 6'b000000, 0, 1,
         74'd0, 0, 0, 6'd27, 6'd7);
    // dual lane: both lanes negative (-1 high, -2 low)
    send(3'b001, {26'h3FFFFFF, 48'd0}, 48'hFFFFFFFFFFFE, 49'd0, 56'd0, 6'b001001, 0, 1,
         74'h1000002, 1, 1, 6'd28, 6'd28);
    // narrow: simple add, high part of sh_reg ignored
    send(3'b010, {26'h155, 48'd0}, 48'd5, 49'd3, 56'h00000008000000, 6'b000000, 0, 1,
         74'd8, 0, 0, 6'd28, 6'd0);
    // narrow subtract without end carry: -3
    send(3'b010, 74'd0, 48'hFFFFFFFFFFFD, 49'd0, 56'd1, 6'b001000, 0, 1,
         74'd3, 1, 0, 6'd55, 6'd0);
    // narrow subtract with end carry: positive, carry lands in bit 48
    send(3'b010, 74'd0, 48'hFFFFFFFFFFFF, 49'd4, 56'd0, 6'b001000, 0, 1,
         74'h1000000000003, 0, 0, 6'd56, 6'd0);
    // idle mode still carries control
    send(3'b101, {26'h2AAAAAA, 48'd7}, 48'h123456789ABC, 49'h1FFFFFFFFFFFF, 56'hFF, 6'b111111, 0, 1,
         74'd0, 0, 0, 6'd0, 6'd0);
    // full add, Carry[48] into high part, product sign 1
    send(3'b000, 74'd0, 48'h000000000010, 49'h1000000000001, 56'd1, 6'b101000, 0, 1,
         74'h1000000000011, 1, 0, 6'd55, 6'd0);
    idle(3);

    // back-to-back with flush on the second: tokens 1 and 2 die, token 3 survives
    send(3'b000, 74'd0, 48'd1, 49'd1, 56'd0, 6'b000000, 0, 0, 74'd0, 0, 0, 6'd0, 6'd0);
    send(3'b000, 74'd0, 48'd2, 49'd2, 56'd0, 6'b000000, 1, 0, 74'd0, 0, 0, 6'd0, 6'd0);
    send(3'b000, 74'd0, 48'd7, 49'd0, 56'd0, 6'b000000, 0, 1, 74'd7, 0, 0, 6'd56, 6'd0);
    idle(4);

    // reset while a token sits between stage A and stage B
    send(3'b000, 74'd0, 48'd9, 49'd0, 56'd0, 6'b000000, 0, 0, 74'd0, 0, 0, 6'd0, 6'd0);
    bus.in_valid = 1'b0;
    #2 rstn = 1'b0;
    #1 chk_zero("midrst");
    @(posedge clk); #1 rstn = 1'b1;
    idle(1);
    send(3'b000, 74'd0, 48'h00000000ABCD, 49'd1, 56'h00000000000100, 6'b000000, 0, 1,
         74'hABCE, 0, 0, 6'd47, 6'd0);
    idle(1);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() > 0) begin
      vectors++;
      errors++;
      $display("FAIL drain: %0d expected results never appeared, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
